// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the AXI-Lite interrupt controller: register indices,
// response codes and small bit-manipulation helpers.
package irq_ctrl_pkg;

    typedef logic [2:0] reg_idx_t;

    // Word index taken from address bits [4:2]
    localparam reg_idx_t REG_PENDING  = 3'd0;
    localparam reg_idx_t REG_ENABLE   = 3'd1;
    localparam reg_idx_t REG_EDGE_SEL = 3'd2;
    localparam reg_idx_t REG_CLAIM    = 3'd3;
    localparam reg_idx_t REG_RAW      = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = i[4:0];
        end
        return idx;
    endfunction

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer for the raw sources plus a history flop; the rising
// edge indication is registered so edge-mode pending lags level mode by one.
module irq_sync_edge #(
    parameter int NUM_IRQ = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_IRQ-1:0] i_src,
    output logic [NUM_IRQ-1:0] o_s,
    output logic [NUM_IRQ-1:0] o_rise
);

    logic [NUM_IRQ-1:0] r_sync1;
    logic [NUM_IRQ-1:0] r_sync2;
    logic [NUM_IRQ-1:0] r_prev;
    logic [NUM_IRQ-1:0] r_rise;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_rise  <= '0;
        end else begin
            r_sync1 <= i_src;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_rise  <= r_sync2 & ~r_prev;
        end
    end

    assign o_s    = r_sync2;
    assign o_rise = r_rise;

endmodule

// File: rtl/axil_irq_ctrl.sv
// AXI-Lite interrupt controller: latches synchronized sources into PENDING,
// masks with ENABLE and drives a single registered irq to the core.
module axil_irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_IRQ    = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_IRQ-1:0]    i_src,
    output logic                  o_irq,
    input  logic [ADDR_WIDTH-1:0] i_awaddr,
    input  logic [2:0]            i_awprot,
    input  logic                  i_awvalid,
    output logic                  o_awready,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [STRB_WIDTH-1:0] i_wstrb,
    input  logic                  i_wvalid,
    output logic                  o_wready,
    output logic [1:0]            o_bresp,
    output logic                  o_bvalid,
    input  logic                  i_bready,
    input  logic [ADDR_WIDTH-1:0] i_araddr,
    input  logic [2:0]            i_arprot,
    input  logic                  i_arvalid,
    output logic                  o_arready,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [1:0]            o_rresp,
    output logic                  o_rvalid,
    input  logic                  i_rready
);

    localparam int PAD = 32 - NUM_IRQ;

    logic [NUM_IRQ-1:0] w_s;
    logic [NUM_IRQ-1:0] w_rise;

    irq_sync_edge #(.NUM_IRQ(NUM_IRQ)) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_src   (i_src),
        .o_s     (w_s),
        .o_rise  (w_rise)
    );

    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_enable;
    logic [NUM_IRQ-1:0] r_edge_sel;
    logic               r_irq;
    logic               r_bvalid;
    logic [1:0]         r_bresp;
    logic               r_rvalid;
    logic [1:0]         r_rresp;
    logic [31:0]        r_rdata;

    reg_idx_t           w_widx;
    reg_idx_t           w_ridx;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic [31:0]        w_strb32;
    logic [31:0]        w_wbits32;
    logic [NUM_IRQ-1:0] w_lmask;
    logic [NUM_IRQ-1:0] w_wbits;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_pe;
    logic [31:0]        w_claim;
    logic [31:0]        w_rd_data;
    logic [1:0]         w_rd_resp;
    logic [1:0]         w_wr_resp;

    assign w_widx   = i_awaddr[4:2];
    assign w_ridx   = i_araddr[4:2];

    // Readies are gated by reset so nothing handshakes while rst is low
    assign w_wr_acc  = i_awvalid & i_wvalid & ~r_bvalid & i_rst_n;
    assign w_rd_acc  = i_arvalid & ~r_rvalid & i_rst_n;
    assign o_awready = w_wr_acc;
    assign o_wready  = w_wr_acc;
    assign o_arready = ~r_rvalid & i_rst_n;

    assign w_strb32  = strb_mask(i_wstrb);
    assign w_wbits32 = i_wdata & w_strb32;
    assign w_lmask   = w_strb32[NUM_IRQ-1:0];
    assign w_wbits   = w_wbits32[NUM_IRQ-1:0];
    assign w_clr     = (w_wr_acc && (w_widx == REG_PENDING)) ? w_wbits : '0;

    assign w_pe      = r_pending & r_enable;
    assign w_claim   = {|w_pe, 26'd0, lowest_set({{PAD{1'b0}}, w_pe})};
    assign w_wr_resp = (w_widx > REG_RAW) ? RESP_SLVERR : RESP_OKAY;

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        case (w_ridx)
            REG_PENDING:  w_rd_data = {{PAD{1'b0}}, r_pending};
            REG_ENABLE:   w_rd_data = {{PAD{1'b0}}, r_enable};
            REG_EDGE_SEL: w_rd_data = {{PAD{1'b0}}, r_edge_sel};
            REG_CLAIM:    w_rd_data = w_claim;
            REG_RAW:      w_rd_data = {{PAD{1'b0}}, w_s};
            default:      w_rd_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending  <= '0;
            r_enable   <= '0;
            r_edge_sel <= '0;
            r_irq      <= 1'b0;
        end else begin
            // Edge bits: a new rise beats a same-cycle clear. Level bits follow s.
            r_pending <= (r_edge_sel & (w_rise | (r_pending & ~w_clr)))
                       | (~r_edge_sel & w_s);
            r_irq     <= |w_pe;
            if (w_wr_acc && (w_widx == REG_ENABLE))
                r_enable <= (r_enable & ~w_lmask) | w_wbits;
            if (w_wr_acc && (w_widx == REG_EDGE_SEL))
                r_edge_sel <= (r_edge_sel & ~w_lmask) | w_wbits;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
            r_rvalid <= 1'b0;
            r_rresp  <= RESP_OKAY;
            r_rdata  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_resp;
            end else if (r_bvalid && i_bready) begin
                r_bvalid <= 1'b0;
            end
            if (w_rd_acc) begin
                r_rvalid <= 1'b1;
                r_rresp  <= w_rd_resp;
                r_rdata  <= w_rd_data;
            end else if (r_rvalid && i_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign o_irq    = r_irq;
    assign o_bvalid = r_bvalid;
    assign o_bresp  = r_bresp;
    assign o_rvalid = r_rvalid;
    assign o_rresp  = r_rresp;
    assign o_rdata  = r_rdata;

    logic w_unused;
    assign w_unused = &{1'b0, i_awprot, i_arprot,
                        i_awaddr[ADDR_WIDTH-1:5], i_awaddr[1:0],
                        i_araddr[ADDR_WIDTH-1:5], i_araddr[1:0],
                        w_strb32[31:NUM_IRQ], w_wbits32[31:NUM_IRQ]};

endmodule

// File: tb/tb_axil_irq_ctrl.sv
// Directed plus randomized checks of axil_irq_ctrl against a behavioural
// model of pending/claim/irq built from the register rules.
module tb_axil_irq_ctrl;

    logic        clk;
    logic        rst_n;
    logic [7:0]  src;
    logic        irq;
    logic [7:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int n_checks = 0;
    int n_fail   = 0;

    axil_irq_ctrl dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_src     (src),
        .o_irq     (irq),
        .i_awaddr  (awaddr),
        .i_awprot  (awprot),
        .i_awvalid (awvalid),
        .o_awready (awready),
        .i_wdata   (wdata),
        .i_wstrb   (wstrb),
        .i_wvalid  (wvalid),
        .o_wready  (wready),
        .o_bresp   (bresp),
        .o_bvalid  (bvalid),
        .i_bready  (bready),
        .i_araddr  (araddr),
        .i_arprot  (arprot),
        .i_arvalid (arvalid),
        .o_arready (arready),
        .o_rdata   (rdata),
        .o_rresp   (rresp),
        .o_rvalid  (rvalid),
        .i_rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns 1 time unit after the accept edge; response still pending.
    task automatic wr_issue(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int cnt;
        cnt = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        #1;
        while (!awready && cnt < 20) begin
            @(posedge clk); #1; cnt++;
        end
        check("aw_accept_in_budget", (cnt < 20) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [7:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [1:0] exp_resp);
        wr_issue(addr, data, strb);
        check({tag, "_bvalid"}, {31'd0, bvalid}, 32'd1);
        check({tag, "_bresp"}, {30'd0, bresp}, {30'd0, exp_resp});
        bready = 1'b1;
        tick(1);
        bready = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] addr,
                      output logic [31:0] data, output logic [1:0] resp);
        int cnt;
        cnt = 0;
        araddr = addr; arvalid = 1'b1;
        #1;
        while (!arready && cnt < 20) begin
            @(posedge clk); #1; cnt++;
        end
        check({tag, "_ar_in_budget"}, (cnt < 20) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
        data = rdata; resp = rresp;
        rready = 1'b1;
        tick(1);
        rready = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] addr,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp);
        logic [31:0] d;
        logic [1:0]  r;
        rd(tag, addr, d, r);
        check({tag, "_data"}, d, exp_data);
        check({tag, "_resp"}, {30'd0, r}, {30'd0, exp_resp});
    endtask

    function automatic logic [31:0] model_claim(input logic [7:0] pe);
        logic [31:0] c;
        c = 32'd0;
        for (int i = 0; i < 8; i++) begin
            if (pe[i]) begin
                c = 32'h8000_0000 | i;
                break;
            end
        end
        return c;
    endfunction

    initial begin
        logic [7:0] m_e, m_en, m_pend, m_h, m_prev, m_c;

        rst_n = 1'b0; src = '0;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;

        // Readies held low during reset even with valids up
        #12;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        #1;
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_wready",  {31'd0, wready},  32'd0);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_irq",     {31'd0, irq},     32'd0);
        check("rst_bvalid",  {31'd0, bvalid},  32'd0);
        check("rst_rvalid",  {31'd0, rvalid},  32'd0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        #20;
        rst_n = 1'b1;
        tick(2);

        rd_chk("rst_pending", 8'h00, 32'd0, 2'b00);
        rd_chk("rst_enable",  8'h04, 32'd0, 2'b00);
        rd_chk("rst_edgesel", 8'h08, 32'd0, 2'b00);
        rd_chk("rst_claim",   8'h0C, 32'd0, 2'b00);
        rd_chk("rst_raw",     8'h10, 32'd0, 2'b00);
        rd_chk("rd_badaddr",  8'h14, 32'd0, 2'b10);
        check("rst_irq_after", {31'd0, irq}, 32'd0);

        // Edge-mode latency on src[2]
        wr("cfg_edge", 8'h08, 32'h04, 4'hF, 2'b00);
        wr("cfg_en",   8'h04, 32'h04, 4'hF, 2'b00);
        src = 8'h04;
        tick(1);
        src = 8'h00;
        tick(3);
        check("edge_irq_n3", {31'd0, irq}, 32'd0);
        tick(1);
        check("edge_irq_n4", {31'd0, irq}, 32'd1);
        rd_chk("edge_pending", 8'h00, 32'h04, 2'b00);
        rd_chk("edge_claim",   8'h0C, 32'h8000_0002, 2'b00);

        // W1C with bvalid held under backpressure; a second write must stall
        wr_issue(8'h00, 32'h04, 4'hF);
        check("w1c_bvalid0", {31'd0, bvalid}, 32'd1);
        check("w1c_bresp",   {30'd0, bresp},  32'd0);
        awaddr = 8'h04; wdata = 32'hFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick(1);
        check("w1c_irq_low",     {31'd0, irq},     32'd0);
        check("w1c_bvalid1",     {31'd0, bvalid},  32'd1);
        check("busy_awready",    {31'd0, awready}, 32'd0);
        tick(1);
        check("w1c_bvalid2",     {31'd0, bvalid},  32'd1);
        tick(1);
        check("w1c_bvalid3",     {31'd0, bvalid},  32'd1);
        check("w1c_bresp_held",  {30'd0, bresp},   32'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        tick(1);
        bready = 1'b0;
        check("w1c_bvalid_drop", {31'd0, bvalid}, 32'd0);
        rd_chk("w1c_pending",    8'h00, 32'h00, 2'b00);
        rd_chk("busy_no_update", 8'h04, 32'h04, 2'b00);

        // Rising edge lands on the same cycle as the W1C of that bit
        src = 8'h04;
        tick(1);
        src = 8'h00;
        tick(2);
        wr_issue(8'h00, 32'h04, 4'hF);
        bready = 1'b1;
        tick(1);
        bready = 1'b0;
        rd_chk("set_beats_clr", 8'h00, 32'h04, 2'b00);

        // Level mode
        wr("cfg_level", 8'h08, 32'h00, 4'hF, 2'b00);
        wr("cfg_en3",   8'h04, 32'h03, 4'hF, 2'b00);
        src = 8'h03;
        tick(5);
        rd_chk("lvl_claim0", 8'h0C, 32'h8000_0000, 2'b00);
        rd_chk("lvl_raw",    8'h10, 32'h03, 2'b00);
        wr("lvl_w1c", 8'h00, 32'h02, 4'hF, 2'b00);
        tick(1);
        rd_chk("lvl_w1c_noeffect", 8'h00, 32'h03, 2'b00);
        src = 8'h02;
        tick(4);
        rd_chk("lvl_claim1", 8'h0C, 32'h8000_0001, 2'b00);
        src = 8'h00;
        tick(3);
        check("lvl_irq_n2", {31'd0, irq}, 32'd1);
        tick(1);
        check("lvl_irq_n3", {31'd0, irq}, 32'd0);

        // Byte strobes and unused upper bits
        wr("en_zero", 8'h04, 32'h0, 4'hF, 2'b00);
        wr("en_strb0", 8'h04, 32'hFFFF_FFFF, 4'b0001, 2'b00);
        rd_chk("en_strb0_rd", 8'h04, 32'hFF, 2'b00);
        wr("en_upper_lanes", 8'h04, 32'h0, 4'b1110, 2'b00);
        rd_chk("en_upper_rd", 8'h04, 32'hFF, 2'b00);

        // AW-only and W-only are never accepted
        awaddr = 8'h04; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("aw_only_awready", {31'd0, awready}, 32'd0);
            tick(1);
        end
        awvalid = 1'b0; wvalid = 1'b1;
        #1;
        check("w_only_wready", {31'd0, wready}, 32'd0);
        tick(1);
        wvalid = 1'b0;
        check("aw_only_no_bvalid", {31'd0, bvalid}, 32'd0);
        rd_chk("aw_only_no_update", 8'h04, 32'hFF, 2'b00);

        wr("wr_claim", 8'h0C, 32'hFFFF_FFFF, 4'hF, 2'b00);
        wr("wr_raw",   8'h10, 32'hFFFF_FFFF, 4'hF, 2'b00);
        wr("wr_bad",   8'h18, 32'hFFFF_FFFF, 4'hF, 2'b10);
        rd_chk("wr_bad_noeffect", 8'h08, 32'h00, 2'b00);

        // Randomized mix of edge/level bits against the model
        m_e  = 8'($urandom_range(0, 255));
        m_en = 8'($urandom_range(0, 255));
        src = 8'h00;
        wr("rnd_edge", 8'h08, {24'd0, m_e}, 4'hF, 2'b00);
        wr("rnd_en",   8'h04, {24'd0, m_en}, 4'hF, 2'b00);
        tick(6);
        wr("rnd_clr",  8'h00, 32'hFF, 4'hF, 2'b00);
        m_pend = 8'h00;
        m_prev = 8'h00;
        for (int it = 0; it < 10; it++) begin
            m_h = 8'($urandom_range(0, 255));
            src = m_h;
            tick(7);
            m_pend = (m_e & (m_pend | (m_h & ~m_prev))) | (~m_e & m_h);
            m_prev = m_h;
            rd_chk("rnd_pending", 8'h00, {24'd0, m_pend}, 2'b00);
            rd_chk("rnd_claim",   8'h0C, model_claim(m_pend & m_en), 2'b00);
            rd_chk("rnd_raw",     8'h10, {24'd0, m_h}, 2'b00);
            check("rnd_irq", {31'd0, irq}, {31'd0, |(m_pend & m_en)});
            if (it % 2 == 1) begin
                m_c = 8'($urandom_range(0, 255));
                wr("rnd_w1c", 8'h00, {24'd0, m_c}, 4'hF, 2'b00);
                m_pend = m_pend & ~(m_c & m_e);
                tick(2);
                rd_chk("rnd_after_w1c", 8'h00, {24'd0, m_pend}, 2'b00);
            end
        end

        // Reset in the middle of an outstanding write response
        wr_issue(8'h04, 32'h5A, 4'hF);
        check("mid_bvalid", {31'd0, bvalid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("mid_rst_irq",    {31'd0, irq},    32'd0);
        #3;
        rst_n = 1'b1;
        src = 8'h00;
        tick(3);
        rd_chk("mid_rst_enable",  8'h04, 32'h00, 2'b00);
        rd_chk("mid_rst_edgesel", 8'h08, 32'h00, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_irq_ctrl.md
Name: axil_irq_ctrl

Overview:
- AXI-Lite interrupt controller on a spare crossbar master port (e.g. base 0x40000000); replaces the ad-hoc core irq compare logic in the SoC top.
- Collects interrupt sources (frame-counter tick, PS/2, UART), synchronizes them, latches pending bits, masks them and drives the single core irq input.
- Software reads CLAIM to find the source and clears it through PENDING (write-1-to-clear).

Parameters:
- NUM_IRQ, 8, number of source lines, 1..31.
- ADDR_WIDTH, 8, AXI-Lite address width; only bits [4:2] are decoded.
- DATA_WIDTH, 32, fixed at 32.
- STRB_WIDTH, 4, DATA_WIDTH/8.

Ports:
- clk  in  1  system clock (dclk domain).
- rst  in  1  asynchronous, active-low reset.
- src  in  NUM_IRQ  raw interrupt sources; may be asynchronous to clk.
- irq  out  1  registered request to core.
- awaddr in ADDR_WIDTH; awprot in 3 (ignored); awvalid in 1; awready out 1.
- wdata in 32; wstrb in 4; wvalid in 1; wready out 1.
- bresp out 2; bvalid out 1; bready in 1.
- araddr in ADDR_WIDTH; arprot in 3 (ignored); arvalid in 1; arready out 1.
- rdata out 32; rresp out 2; rvalid out 1; rready in 1.

Behaviour:
- Reset (rst=0, async): PENDING, ENABLE, EDGE_SEL, sync flops and edge-history flops = 0; irq=0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0. All ready outputs = 0 while reset is asserted.
- Register map (offset, access, reset value):
  - 0x00 PENDING: R / W1C, 0.
  - 0x04 ENABLE: RW, 0.
  - 0x08 EDGE_SEL: RW, 0; 1=rising-edge source, 0=level source.
  - 0x0C CLAIM: RO. bit31 = any pending&enable; bits[4:0] = lowest index set in pending&enable, 0 if none. Reading does not clear.
  - 0x10 RAW: RO, synchronized src.
  - Any other offset: SLVERR (2'b10); write has no effect; rdata=0.
  - Bits at or above NUM_IRQ read as 0 and ignore writes.
- Input path:
  - 2-flop synchronizer, then 1 history flop (s_prev).
  - Edge mode: pending[i] set when s[i] & !s_prev[i].
  - Level mode: pending[i] = s[i] every cycle; W1C has no lasting effect.
- Latency: src first sampled high at edge N → PENDING reads 1 from edge N+2 (edge mode: N+3) → irq=1 one edge later.
- irq <= |(pending & enable), registered. Masked bits stay pending.
- Simultaneous edge-set and W1C on the same bit in one cycle: set wins, bit stays 1.
- Switching EDGE_SEL 0→1 keeps the current pending value; no spurious edge is generated.
- Write channel:
  - awready = wready = awvalid & wvalid & !bvalid (combinational, single-cycle accept). AW or W alone is never accepted.
  - Register update occurs on the accept edge. bvalid rises the next cycle and is held with bresp until bready.
  - No new write is accepted while bvalid=1.
  - wstrb: for ENABLE/EDGE_SEL only strobed byte lanes update. For W1C, only bits in strobed lanes clear.
  - Writes to CLAIM or RAW: ignored, bresp OKAY.
- Read channel:
  - arready = !rvalid. On accept, rdata/rresp are registered and rvalid=1 on the next cycle, held stable until rready.
  - Back-to-back reads: one accept per two cycles minimum.
- Read and write in the same cycle are independent; the read returns pre-write register values.
- Reset asserted mid-transaction: all state clears immediately and the outstanding response is dropped. The master must also be reset (same rst).

Decomposition:
- Package irq_ctrl_pkg: register offset localparams (REG_PENDING..REG_RAW), RESP_OKAY=2'b00, RESP_SLVERR=2'b10, typedef for the 3-bit decoded register index.
- One sub-module, irq_sync_edge: parameterized NUM_IRQ-wide synchronizer plus history flop. Outputs s and rise.

Test Plan:
- Reset then read every register → PENDING/ENABLE/EDGE_SEL/CLAIM/RAW = 0, rresp=0, irq=0; read 0x14 → rresp=2'b10, rdata=0.
- Write EDGE_SEL=0x04, ENABLE=0x04; pulse src[2] high for 1 cycle → PENDING=0x04 at edge N+3, irq=1 at N+4; CLAIM=0x80000002.
- W1C 0x04 to PENDING → PENDING=0, irq=0 one cycle after write accept; bvalid held across 3 cycles of bready=0 with bresp=0.
- Edge on src[2] in the same cycle as W1C of bit 2 → PENDING stays 0x04.
- Level mode, ENABLE=0x03, src=0x03 held → CLAIM=0x80000000; drop src[0] → CLAIM=0x80000001 after 3 cycles; drop src[1] → irq=0.
- ENABLE write 0xFFFFFFFF with wstrb=4'b0001 after ENABLE=0 → ENABLE reads 0xFF (NUM_IRQ=8); AW-only valid for 5 cycles → awready stays 0, no update.
